// File: rtl/fp_iter_unit.sv
// Multi-cycle FP32 add/multiply unit: unpack, align, add, normalise for FADD and
// shift-add mantissa product for FMUL. Rounding is truncation toward zero throughout.
module fp_iter_unit #(
    parameter int unsigned MUL_ITER = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  ALUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic [31:0] Result,
    output logic [3:0]  Flags,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        StIdle, StUnpack, StAlign, StAdd, StNorm, StMul, StMnorm, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] srca_q, srca_d, srcb_q, srcb_d;
    logic        is_mul_q, is_mul_d;
    logic        sign_q, sign_d;
    logic        sub_q, sub_d;
    logic [7:0]  exp_q, exp_d;
    logic [23:0] mant_l_q, mant_l_d, mant_s_q, mant_s_d;
    logic [24:0] sum_q, sum_d;
    logic [47:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q;
    logic [3:0]  flags_q;
    logic        res_load;
    logic [31:0] res_val;

    logic        sa, sb, a_zero, b_zero, a_ge_b;
    logic [7:0]  ea, eb, diff;
    logic [23:0] ma, mb;
    logic signed [9:0] mexp;
    logic [22:0] mmant;

    assign sa     = srca_q[31];
    assign sb     = srcb_q[31];
    assign ea     = srca_q[30:23];
    assign eb     = srcb_q[30:23];
    assign ma     = {1'b1, srca_q[22:0]};
    assign mb     = {1'b1, srcb_q[22:0]};
    // Exponent zero covers both true zeros and denormals (flushed).
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_ge_b = ({ea, ma} >= {eb, mb});
    assign diff   = a_ge_b ? (ea - eb) : (eb - ea);

    assign mexp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
                 + $signed({9'd0, acc_q[47]});
    assign mmant = acc_q[47] ? 23'(acc_q >> 24) : 23'(acc_q >> 23);

    always_comb begin
        state_d  = state_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        is_mul_d = is_mul_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        exp_d    = exp_q;
        mant_l_d = mant_l_q;
        mant_s_d = mant_s_q;
        sum_d    = sum_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_load = 1'b0;
        res_val  = 32'd0;
        unique case (state_q)
            StIdle: begin
                if (start && (ALUControl == 3'b100 || ALUControl == 3'b101)) begin
                    srca_d   = SrcA;
                    srcb_d   = SrcB;
                    is_mul_d = ALUControl[0];
                    state_d  = StUnpack;
                end
            end
            StUnpack: begin
                state_d = StDone;
                if (ea == 8'hFF || eb == 8'hFF) begin
                    res_load = 1'b1;
                    res_val  = 32'h7FC0_0000;
                end else if (is_mul_q) begin
                    if (a_zero || b_zero) begin
                        res_load = 1'b1;
                        res_val  = {sa ^ sb, 31'd0};
                    end else begin
                        acc_d   = 48'd0;
                        cnt_d   = 5'd0;
                        state_d = StMul;
                    end
                end else if (a_zero && b_zero) begin
                    res_load = 1'b1;
                    res_val  = 32'd0;
                end else if (a_zero) begin
                    res_load = 1'b1;
                    res_val  = srcb_q;
                end else if (b_zero) begin
                    res_load = 1'b1;
                    res_val  = srca_q;
                end else begin
                    state_d = StAlign;
                end
            end
            StAlign: begin
                sign_d   = a_ge_b ? sa : sb;
                exp_d    = a_ge_b ? ea : eb;
                mant_l_d = a_ge_b ? ma : mb;
                mant_s_d = (diff >= 8'd25) ? 24'd0 : ((a_ge_b ? mb : ma) >> diff);
                sub_d    = sa ^ sb;
                state_d  = StAdd;
            end
            StAdd: begin
                sum_d   = sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                                : ({1'b0, mant_l_q} + {1'b0, mant_s_q});
                state_d = StNorm;
            end
            StNorm: begin
                if (sum_q[24]) begin
                    res_load = 1'b1;
                    res_val  = (exp_q == 8'd254) ? {sign_q, 8'hFF, 23'd0}
                                                 : {sign_q, exp_q + 8'd1, 23'(sum_q >> 1)};
                    state_d  = StDone;
                end else if (sum_q == 25'd0) begin
                    res_load = 1'b1;
                    res_val  = 32'd0;
                    state_d  = StDone;
                end else if (sum_q[23]) begin
                    res_load = 1'b1;
                    res_val  = {sign_q, exp_q, sum_q[22:0]};
                    state_d  = StDone;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 8'd1;
                    if (exp_q == 8'd1) begin
                        res_load = 1'b1;
                        res_val  = {sign_q, 31'd0};
                        state_d  = StDone;
                    end
                end
            end
            StMul: begin
                acc_d = acc_q + (mb[cnt_q] ? ({24'd0, ma} << cnt_q) : 48'd0);
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(MUL_ITER - 1)) begin
                    state_d = StMnorm;
                end
            end
            StMnorm: begin
                res_load = 1'b1;
                if (mexp >= 10'sd255) begin
                    res_val = {sa ^ sb, 8'hFF, 23'd0};
                end else if (mexp <= 10'sd0) begin
                    res_val = {sa ^ sb, 31'd0};
                end else begin
                    res_val = {sa ^ sb, mexp[7:0], mmant};
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            srca_q   <= 32'd0;
            srcb_q   <= 32'd0;
            is_mul_q <= 1'b0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            exp_q    <= 8'd0;
            mant_l_q <= 24'd0;
            mant_s_q <= 24'd0;
            sum_q    <= 25'd0;
            acc_q    <= 48'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            flags_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            is_mul_q <= is_mul_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            exp_q    <= exp_d;
            mant_l_q <= mant_l_d;
            mant_s_q <= mant_s_d;
            sum_q    <= sum_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            if (res_load) begin
                result_q <= res_val;
                flags_q  <= {res_val[31], (res_val[30:0] == 31'd0), 2'b00};
            end
        end
    end

    assign Result = result_q;
    assign Flags  = flags_q;
    assign busy   = (state_q != StIdle) && (state_q != StDone);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_fp_iter_unit.sv
// Scoreboard bench for fp_iter_unit: stimulus pushes expected result/flags/completion
// cycle; a negedge monitor pops and compares on every done pulse.
module tb_fp_iter_unit;

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA, SrcB;
    logic [31:0] Result;
    logic [3:0]  Flags;
    logic        busy, done;

    fp_iter_unit #(.MUL_ITER(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Result     (Result),
        .Flags      (Flags),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  flg;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        inflight = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] held_res = 32'd0;
    logic [3:0]  held_flg = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_done) chk("single_pulse", {63'd0, done}, 64'd0);
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, "_result"}, {32'd0, Result}, {32'd0, e.res});
                    chk({e.name, "_flags"}, {60'd0, Flags}, {60'd0, e.flg});
                    chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
                    chk({e.name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
                    held_res = e.res;
                    held_flg = e.flg;
                    inflight = 1'b0;
                end
                prev_done = 1'b1;
            end else begin
                prev_done = 1'b0;
                if (inflight) begin
                    chk("busy_inflight", {63'd0, busy}, 64'd1);
                end else begin
                    chk("busy_idle", {63'd0, busy}, 64'd0);
                    chk("hold_result", {32'd0, Result}, {32'd0, held_res});
                    chk("hold_flags", {60'd0, Flags}, {60'd0, held_flg});
                end
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                         input int lat);
        exp_t e;
        @(negedge clk);
        start      = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.name = nm;
        e.res  = er;
        e.flg  = ef;
        e.due  = cyc + lat;
        q.push_back(e);
        inflight = 1'b1;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk({nm, "_timeout"}, 64'(q.size()), 64'd0);
        if (q.size() != 0) begin
            q.delete();
            inflight = 1'b0;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                       input int lat);
        issue(nm, op, a, b, er, ef, lat);
        wait_done(nm);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        ALUControl = 3'b000;
        SrcA       = 32'd0;
        SrcB       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", {32'd0, Result}, 64'd0);
        chk("reset_flags", {60'd0, Flags}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run("add_1p1",     OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000, 4);
        run("add_1m075",   OP_ADD, 32'h3F80_0000, 32'hBF40_0000, 32'h3E80_0000, 4'b0000, 6);
        run("add_cancel",  OP_ADD, 32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000, 4'b0100, 4);
        run("add_far",     OP_ADD, 32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 4'b0000, 4);
        run("add_ovf",     OP_ADD, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 4'b0000, 4);
        run("add_uflow",   OP_ADD, 32'h0080_0000, 32'h80C0_0000, 32'h8000_0000, 4'b1100, 4);
        run("add_nan",     OP_ADD, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000, 1);
        run("add_zero_a",  OP_ADD, 32'h0000_0000, 32'h4040_0000, 32'h4040_0000, 4'b0000, 1);
        run("add_zeros",   OP_ADD, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100, 1);
        run("mul_2xm3",    OP_MUL, 32'h4000_0000, 32'hC040_0000, 32'hC0C0_0000, 4'b1000, 26);
        run("mul_ovf",     OP_MUL, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0000, 26);
        run("mul_zero",    OP_MUL, 32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 4'b1100, 1);

        // Unsupported op code: must not start.
        @(negedge clk);
        start      = 1'b1;
        ALUControl = 3'b000;
        SrcA       = 32'h3F80_0000;
        SrcB       = 32'h3F80_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ignored_op_busy", {63'd0, busy}, 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("ignored_op_done", {63'd0, done}, 64'd0);

        // Second start during MUL must not disturb the running multiply.
        issue("mul_restart", OP_MUL, 32'h4000_0000, 32'hC040_0000, 32'hC0C0_0000, 4'b1000, 26);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start      = 1'b1;
        ALUControl = OP_ADD;
        SrcA       = 32'h3F80_0000;
        SrcB       = 32'h3F80_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("mul_restart");

        // Asynchronous reset in the middle of a multiply.
        issue("mul_aborted", OP_MUL, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4'b0000, 26);
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_result", {32'd0, Result}, 64'd0);
        chk("midreset_flags", {60'd0, Flags}, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_done", {63'd0, done}, 64'd0);
        q.delete();
        inflight  = 1'b0;
        prev_done = 1'b0;
        held_res  = 32'd0;
        held_flg  = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        run("add_after_reset", OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_iter_unit.md
Name: fp_iter_unit

Overview:
- Multi-cycle IEEE-754 single-precision add/multiply unit. It sits downstream of the instruction decoder and executes the float operations the decoder flags on ALUControl (3'b100 FADD, 3'b101 FMUL).
- The datapath stalls on busy, latches Result when done pulses, and routes Flags into the condition-flag logic under FlagW.
- Integer ALU ops never enter this block.

Parameters:
- MUL_ITER, 24, shift-add iterations for the mantissa product; fixed at 24 for FP32.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- ALUControl  in  3  operation: 100 add, 101 multiply; other codes are ignored
- SrcA  in  32  operand A (FP32)
- SrcB  in  32  operand B (FP32)
- Result  out  32  FP32 result
- Flags  out  4  {N,Z,C,V}
- busy  out  1  high from the accepting edge until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset=0): state IDLE; Result=0, Flags=0, busy=0, done=0; internal registers cleared. Reset during any state aborts the operation with no done.
- Notation: E0 is the edge that samples start=1 in IDLE with ALUControl 100 or 101. Operands and op are latched at E0, and busy=1 from E0.
- start in IDLE with any other ALUControl code: ignored; stays IDLE, no done.
- start while busy: ignored.
- States: IDLE, UNPACK, ALIGN, ADD, NORM, MUL, MNORM, DONE.
  - UNPACK (1 cycle):
    - sign, 8-bit exponent, 24-bit mantissa with hidden 1.
    - exp==0 means zero; denormals flush to zero.
    - Shortcuts go to DONE. Any operand with exp==255 gives 0x7FC00000. FADD with one zero operand gives the other operand; two zeros give +0. FMUL with a zero operand gives a zero with sign = sA^sB.
    - Otherwise FADD goes to ALIGN and FMUL goes to MUL.
  - ALIGN (1 cycle):
    - order the operands by magnitude {exp,mant}.
    - shift the smaller mantissa right by the exponent difference; difference >=25 gives 0. Truncate, no guard bits.
  - ADD (1 cycle):
    - 25-bit sum if the signs are equal, else larger minus smaller.
    - result sign = sign of the larger operand.
  - NORM (one decision per cycle):
    - bit24 set: shift right 1, exp+1, go DONE.
    - sum==0: result +0, go DONE.
    - bit23 set: go DONE.
    - otherwise: shift left 1, exp-1, stay. If exp reaches 0, flush to signed zero and go DONE.
    - exp reaching 255 after the right shift gives signed Inf (0x7F800000|sign).
  - MUL (24 cycles):
    - 24x24 shift-add into a 48-bit accumulator.
    - 5-bit counter 0..23; goes to MNORM after the last iteration.
  - MNORM (1 cycle):
    - exponent computed in 10-bit signed arithmetic: eA+eB-127.
    - product[47] set: mantissa = product[46:24], exp+1; else mantissa = product[45:23]. Truncate.
    - exp>=255 gives signed Inf. exp<=0 gives signed zero.
  - DONE (1 cycle):
    - Result and Flags are registered on entry.
    - done=1 and busy=0 during DONE; next state IDLE.
- Flags: N = Result[31]; Z = (Result[30:0]==0); C=0; V=0.
- Result and Flags hold stable from done until the next accepted start.
- Latency in edges after E0:
  - shortcuts: done high after E1.
  - FADD: done high after E(3+k), where k = number of NORM cycles.
  - FMUL: done high after E26.
- Rounding: truncation toward zero, everywhere.

Test Plan:
- FADD 0x3F800000 + 0x3F800000 -> Result 0x40000000, Flags 0000, done after E4, busy high E0..E4.
- FADD 0x3F800000 + 0xBF400000 -> two left shifts, Result 0x3E800000, done after E6.
- FADD 0x3FC00000 + 0xBFC00000 -> Result 0x00000000, Flags 0100 (Z).
- FMUL 0x40000000 * 0xC0400000 -> Result 0xC0C00000, Flags 1000, done exactly after E26, single-cycle pulse.
- FMUL 0x7F000000 * 0x7F000000 -> 0x7F800000. FMUL 0x00000000 * 0xC0000000 -> 0x80000000, Flags 1100, done after E1.
- Control corner cases:
  - start with ALUControl=000 -> no busy, no done.
  - start pulsed during MUL -> ignored, original result returned.
  - reset=0 mid-MUL -> all outputs 0 immediately; a new op after release completes correctly.
